cross_bar_slave_mem: RTL

- Downstream slave endpoint of the cross-bar. It terminates the master side of `cross_bar_if` driven by the arbiter controller.
- Serves single-beat reads and writes from a word-addressed on-chip memory, with programmable ack and read-response latency.
- Keeps per-type transaction counters and an out-of-range error counter for debug and verification.
- Serves as both the reference slave in system benches and a synthesizable scratch memory.

---
 rtl/cross_bar_pkg.sv | 17 +
 rtl/cross_bar_if.sv | 17 +
 rtl/cross_bar_sram.sv | 22 ++
 rtl/cross_bar_slave_mem.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
// Shared cross-bar definitions: command encodings, read error pattern and the
// slave endpoint state type.
package cross_bar_pkg;

   localparam logic        CMD_READ    = 1'b0;
   localparam logic        CMD_WRITE   = 1'b1;
   localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACK,
      ACK,
      RD_WAIT,
      RESP
   } slave_state_e;

endpackage

// File: rtl/cross_bar_if.sv
// Single-beat request/ack/response bus between the arbiter controller and a
// cross-bar slave.
interface cross_bar_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              resp;

   modport master (output req, cmd, addr, wdata, input ack, rdata, resp);
   modport slave  (input req, cmd, addr, wdata, output ack, rdata, resp);
endinterface

// File: rtl/cross_bar_sram.sv
// Single-port synchronous RAM, read-before-write, one-cycle registered read.
module cross_bar_sram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                     aclk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/cross_bar_slave_mem.sv
// Cross-bar slave endpoint: word-addressed scratch memory with programmable
// ack / read-response latency and saturating debug counters.
module cross_bar_slave_mem
   import cross_bar_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 256,
   parameter int ACK_LAT   = 1,
   parameter int RD_LAT    = 2,
   parameter int CNT_W     = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   cross_bar_if.slave       s_base,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int IDX_W   = $clog2(MEM_DEPTH);
   localparam int LAT_MAX = (ACK_LAT > RD_LAT) ? ACK_LAT : RD_LAT;
   localparam int LAT_W   = $clog2(LAT_MAX + 1);

   slave_state_e      state, state_nx;
   logic [LAT_W-1:0]  lat_cnt;
   logic              lat_done;
   logic              cmd_q;
   logic              in_range_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_we;
   logic              ack_c;
   logic              resp_c;
   logic [DATA_W-1:0] rdata_c;
   logic              in_range;
   logic              unused_addr_bits;

   assign in_range         = (s_base.addr[ADDR_W-1:IDX_W+2] == '0);
   assign unused_addr_bits = ^s_base.addr[1:0];
   assign lat_done         = (lat_cnt <= LAT_W'(1));

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ack_c    = 1'b0;
      resp_c   = 1'b0;
      rdata_c  = '0;
      ram_we   = 1'b0;
      case (state)
         IDLE: begin
            if (s_base.req) begin
               state_nx = (ACK_LAT == 1) ? ACK : WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (lat_done) begin
               state_nx = ACK;
            end
         end
         ACK: begin
            ack_c  = 1'b1;
            ram_we = (cmd_q == CMD_WRITE) && in_range_q;
            if (cmd_q == CMD_WRITE) begin
               state_nx = IDLE;
            end else begin
               state_nx = (RD_LAT == 1) ? RESP : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (lat_done) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            resp_c   = 1'b1;
            rdata_c  = in_range_q ? ram_rdata : DATA_W'(RD_ERR_DATA);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign s_base.ack   = ack_c;
   assign s_base.resp  = resp_c;
   assign s_base.rdata = rdata_c;

   // Request fields are latched at acceptance; the master may clear them in the ack cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         lat_cnt    <= '0;
         cmd_q      <= CMD_READ;
         in_range_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         err_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_base.req) begin
                  cmd_q      <= s_base.cmd;
                  in_range_q <= in_range;
                  idx_q      <= s_base.addr[IDX_W+1:2];
                  wdata_q    <= s_base.wdata;
                  lat_cnt    <= LAT_W'(ACK_LAT - 1);
               end
            end
            WAIT_ACK, RD_WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
            end
            ACK: begin
               lat_cnt <= LAT_W'(RD_LAT - 1);
               if (cmd_q == CMD_WRITE) begin
                  if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
               end else begin
                  if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
               end
               if (!in_range_q && (err_cnt != '1)) begin
                  err_cnt <= err_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Address is held stable after acceptance, so the registered read output
   // stays valid through RD_WAIT until RESP.
   cross_bar_sram #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_W)
   ) u_sram (
      .aclk  (aclk),
      .we    (ram_we),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule
